prim_diff_decode_mc: RTL and testbench
======================================

PRIM_DIFF_DECODE_MC -- requirements
Module: prim_diff_decode_mc

Interface
REQ-001 SHALL have parameter NumChan, default 4, meaning the number of independent differential pairs (1..32).
REQ-002 SHALL have parameter AsyncOn, default 1'b0, meaning 1 adds a two-flop input synchroniser per wire.
REQ-003 SHALL have parameter MaxSkew, default 1, meaning the maximum number of cycles one wire may lag the other (1..7).
REQ-004 SHALL have parameter CntW, default 8, meaning the width of the signal-integrity (sigint) error counter.
REQ-005 SHALL have a single clock domain, clk_i; reset rst_i is synchronous and active-high.
REQ-006 SHALL have ports: clk_i in 1 clock; rst_i in 1 synchronous active-high reset.
REQ-007 SHALL have ports: diff_pi in NumChan positive wires; diff_ni in NumChan negative wires.
REQ-008 SHALL have ports: level_o, rise_o, fall_o and event_o, each out NumChan, per-channel decoded level and edge pulses.
REQ-009 SHALL have ports: sigint_o out NumChan, live integrity fault; sigint_any_o out 1, OR of sigint_o.
REQ-010 SHALL have ports: sticky_clr_i in NumChan; sigint_sticky_o out NumChan, latched fault flags.
REQ-011 SHALL have ports: cnt_clr_i in 1; err_cnt_o out CntW, saturating count of fault entries.

Function
REQ-012 SHALL, when AsyncOn=1, pass each wire through 2 sync flops, which reset to p=0 and n=1; when AsyncOn=0, it SHALL use the inputs directly.
REQ-013 SHALL register the sampled p/n per channel, resetting to p=0 and n=1, and derive p_edge/n_edge as sample XOR register and ok as p XOR n.
REQ-014 SHALL run a per-channel FSM with states IsStd, IsSkewed and SigInt, whose reset state is IsStd.
REQ-015 SHALL, in IsStd with ok: set level_d=p; if both wires edge, pulse rise_o if p=1 or fall_o if p=0.
REQ-016 SHALL, in IsStd with not ok: go to IsSkewed and load skew_cnt=1 if exactly one wire edged; otherwise go to SigInt and assert sigint_o in the same cycle.
REQ-017 SHALL, in IsSkewed with ok: go to IsStd, set level_d=p and pulse rise_o or fall_o per p.
REQ-018 SHALL, in IsSkewed with not ok: increment skew_cnt if skew_cnt<MaxSkew, otherwise go to SigInt and assert sigint_o.
REQ-019 SHALL, in SigInt: assert sigint_o while not ok; on ok, go to IsStd with sigint_o=0, level held and no pulse.
REQ-020 SHALL drive level_o = level_d combinationally (the next value) and event_o = rise_o | fall_o.
REQ-021 SHALL never assert rise_o and fall_o together, and SHALL make each pulse exactly 1 cycle long.
REQ-022 SHALL define a fault entry as a transition into SigInt.
REQ-023 SHALL set the channel's sigint_sticky_o on a fault entry, and set SHALL win over a simultaneous sticky_clr_i.
REQ-024 SHALL add the popcount of fault entries in a cycle to err_cnt_o, saturating at 2^CntW-1 with no wrap.
REQ-025 SHALL make cnt_clr_i zero err_cnt_o, after which the same cycle's entries are added (result = popcount).
REQ-026 SHALL keep channels fully independent, with no cross-channel interaction other than sigint_any_o and err_cnt_o.
REQ-027 SHALL have latency from input to outputs of 0 cycles (combinational) for AsyncOn=0, and 2 cycles for AsyncOn=1.

Reset
REQ-028 SHALL, while rst_i=1 at a clk_i edge, load: state=IsStd, skew_cnt=0, level_q=0, edge registers p=0/n=1, sync flops p=0/n=1, sticky=0, err_cnt=0.
REQ-029 SHALL, when reset is asserted mid-skew or mid-fault, return to IsStd with no pulse and no count on the following cycle.

Structure
REQ-030 SHALL place state_e (IsStd, IsSkewed, SigInt) and the skew counter width constant in package prim_diff_decode_pkg.
REQ-031 SHALL implement one channel (sync, edge registers, FSM, sticky flag) as sub-module prim_diff_decode_chan, generated NumChan times.
REQ-032 SHALL keep the top level to the popcount, the saturating counter and sigint_any_o.

Verification
REQ-033 SHALL cover: AsyncOn=0, ch0 p/n 0/1 -> 1/0 -> rise_o[0]=1 for 1 cycle with level_o[0]=1; then 1/0 -> 0/1 -> fall_o[0]=1.
REQ-034 SHALL cover: MaxSkew=2, p rises, n falls 2 cycles later -> IsSkewed for 2 cycles, sigint_o=0, single rise_o on the correcting cycle.
REQ-035 SHALL cover: MaxSkew=2, n lags 3 cycles -> sigint_o=1 on the 3rd lag cycle, sticky=1, err_cnt_o=1; it clears on restore with no pulse.
REQ-036 SHALL cover: p=n=1 on 3 channels in the same cycle -> err_cnt_o increments by 3; with CntW=2 starting from 2 -> err_cnt_o=3 (saturated).
REQ-037 SHALL cover: sticky_clr_i[1] in the same cycle as a fault entry on ch1 -> sigint_sticky_o[1] stays 1; cnt_clr_i with 1 entry -> err_cnt_o=1.
REQ-038 SHALL cover: AsyncOn=1, rst_i pulsed while in IsSkewed -> state IsStd, outputs 0, and the first edge response appears 2 cycles after input.

Source files
------------

// File: rtl/prim_diff_decode_pkg.sv
// Shared types for the multi-channel differential decoder: channel FSM states
// and the skew counter width.
package prim_diff_decode_pkg;

    typedef enum logic [1:0] {
        IsStd    = 2'd0,
        IsSkewed = 2'd1,
        SigInt   = 2'd2
    } state_e;

    // Wide enough for the largest allowed skew tolerance (7 cycles).
    localparam int unsigned SkewCntW = 3;

endpackage

// File: rtl/prim_diff_decode_chan.sv
// One differential channel: optional input synchroniser, edge detection,
// skew-tolerant decode FSM and a sticky fault flag.
module prim_diff_decode_chan
    import prim_diff_decode_pkg::*;
#(
    parameter bit          AsyncOn = 1'b0,
    parameter int unsigned MaxSkew = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic diff_pi,
    input  logic diff_ni,
    input  logic sticky_clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic event_o,
    output logic sigint_o,
    output logic sigint_sticky_o,
    output logic fault_o
);

    logic p_s, n_s;

    if (AsyncOn) begin : g_sync
        logic [1:0] p_sync, n_sync;

        // Idle pair is p=0/n=1, so the synchroniser resets to a valid state.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                p_sync <= 2'b00;
                n_sync <= 2'b11;
            end else begin
                p_sync <= {p_sync[0], diff_pi};
                n_sync <= {n_sync[0], diff_ni};
            end
        end

        assign p_s = p_sync[1];
        assign n_s = n_sync[1];
    end else begin : g_nosync
        assign p_s = diff_pi;
        assign n_s = diff_ni;
    end

    logic                p_q, n_q, level_q, sticky_q;
    logic                level_d, p_edge, n_edge, ok;
    logic                rise, fall, sigint;
    state_e              state_q, state_d;
    logic [SkewCntW-1:0] skew_q, skew_d;

    assign p_edge = p_s ^ p_q;
    assign n_edge = n_s ^ n_q;
    assign ok     = p_s ^ n_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q     <= 1'b0;
            n_q     <= 1'b1;
            level_q <= 1'b0;
            state_q <= IsStd;
            skew_q  <= '0;
        end else begin
            p_q     <= p_s;
            n_q     <= n_s;
            level_q <= level_d;
            state_q <= state_d;
            skew_q  <= skew_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skew_d  = skew_q;
        level_d = level_q;
        rise    = 1'b0;
        fall    = 1'b0;
        sigint  = 1'b0;
        unique case (state_q)
            IsStd: begin
                if (ok) begin
                    level_d = p_s;
                    if (p_edge && n_edge) begin
                        rise = p_s;
                        fall = ~p_s;
                    end
                end else if (p_edge ^ n_edge) begin
                    // One wire moved ahead of the other: give it time to catch up.
                    state_d = IsSkewed;
                    skew_d  = SkewCntW'(1);
                end else begin
                    state_d = SigInt;
                    sigint  = 1'b1;
                end
            end
            IsSkewed: begin
                if (ok) begin
                    state_d = IsStd;
                    skew_d  = '0;
                    level_d = p_s;
                    rise    = p_s;
                    fall    = ~p_s;
                end else if (skew_q < SkewCntW'(MaxSkew)) begin
                    skew_d = skew_q + SkewCntW'(1);
                end else begin
                    state_d = SigInt;
                    skew_d  = '0;
                    sigint  = 1'b1;
                end
            end
            SigInt: begin
                // Recovery only restores the decode; level stays where it was.
                if (ok) state_d = IsStd;
                else    sigint  = 1'b1;
            end
            default: begin
                state_d = IsStd;
                skew_d  = '0;
            end
        endcase
    end

    assign fault_o = (state_d == SigInt) && (state_q != SigInt);

    // A new fault wins over a clear arriving in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) sticky_q <= 1'b0;
        else       sticky_q <= fault_o | (sticky_q & ~sticky_clr_i);
    end

    assign level_o         = level_d;
    assign rise_o          = rise;
    assign fall_o          = fall;
    assign event_o         = rise | fall;
    assign sigint_o        = sigint;
    assign sigint_sticky_o = sticky_q;

endmodule

// File: rtl/prim_diff_decode_mc.sv
// Multi-channel differential decoder: an array of independent channel decoders
// plus a shared saturating counter of integrity fault entries.
module prim_diff_decode_mc
    import prim_diff_decode_pkg::*;
#(
    parameter int unsigned NumChan = 4,
    parameter bit          AsyncOn = 1'b0,
    parameter int unsigned MaxSkew = 1,
    parameter int unsigned CntW    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NumChan-1:0] diff_pi,
    input  logic [NumChan-1:0] diff_ni,
    output logic [NumChan-1:0] level_o,
    output logic [NumChan-1:0] rise_o,
    output logic [NumChan-1:0] fall_o,
    output logic [NumChan-1:0] event_o,
    output logic [NumChan-1:0] sigint_o,
    output logic               sigint_any_o,
    input  logic [NumChan-1:0] sticky_clr_i,
    output logic [NumChan-1:0] sigint_sticky_o,
    input  logic               cnt_clr_i,
    output logic [CntW-1:0]    err_cnt_o
);

    // Headroom for adding up to 32 entries on top of a full counter.
    localparam int unsigned SumW = CntW + 6;
    localparam logic [SumW-1:0] CntMax = (SumW'(1) << CntW) - SumW'(1);

    logic [NumChan-1:0] fault;

    for (genvar i = 0; i < NumChan; i++) begin : g_chan
        prim_diff_decode_chan #(
            .AsyncOn (AsyncOn),
            .MaxSkew (MaxSkew)
        ) u_chan (
            .clk_i           (clk_i),
            .rst_i           (rst_i),
            .diff_pi         (diff_pi[i]),
            .diff_ni         (diff_ni[i]),
            .sticky_clr_i    (sticky_clr_i[i]),
            .level_o         (level_o[i]),
            .rise_o          (rise_o[i]),
            .fall_o          (fall_o[i]),
            .event_o         (event_o[i]),
            .sigint_o        (sigint_o[i]),
            .sigint_sticky_o (sigint_sticky_o[i]),
            .fault_o         (fault[i])
        );
    end

    logic [SumW-1:0] n_fault, cnt_sum;
    logic [CntW-1:0] cnt_q;

    always_comb begin
        n_fault = '0;
        for (int i = 0; i < int'(NumChan); i++) n_fault = n_fault + SumW'(fault[i]);
    end

    // Clear acts first, so this cycle's entries still land in the cleared count.
    assign cnt_sum = (cnt_clr_i ? '0 : SumW'(cnt_q)) + n_fault;

    always_ff @(posedge clk_i) begin
        if (rst_i)                 cnt_q <= '0;
        else if (cnt_sum > CntMax) cnt_q <= CntMax[CntW-1:0];
        else                       cnt_q <= cnt_sum[CntW-1:0];
    end

    assign err_cnt_o    = cnt_q;
    assign sigint_any_o = |sigint_o;

endmodule

// File: tb/tb_prim_diff_decode_mc.sv
// Bench for prim_diff_decode_mc: a direct, a narrow-counter and a synchronised
// instance share stimulus and are checked against a lag/fault behavioural model.
module tb_prim_diff_decode_mc;

    localparam int NCH     = 4;
    localparam int MAXSKEW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] diff_p, diff_n, sticky_clr;
    logic           cnt_clr;

    logic [NCH-1:0] d_level, d_rise, d_fall, d_event, d_sig, d_stk;
    logic [NCH-1:0] s_level, s_rise, s_fall, s_event, s_sig, s_stk;
    logic [NCH-1:0] a_level, a_rise, a_fall, a_event, a_sig, a_stk;
    logic           d_any, s_any, a_any;
    logic [7:0]     d_cnt, a_cnt;
    logic [1:0]     s_cnt;

    always #5 clk = ~clk;

    prim_diff_decode_mc #(.NumChan(NCH), .AsyncOn(1'b0), .MaxSkew(MAXSKEW), .CntW(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .diff_pi(diff_p), .diff_ni(diff_n),
        .level_o(d_level), .rise_o(d_rise), .fall_o(d_fall), .event_o(d_event),
        .sigint_o(d_sig), .sigint_any_o(d_any), .sticky_clr_i(sticky_clr),
        .sigint_sticky_o(d_stk), .cnt_clr_i(cnt_clr), .err_cnt_o(d_cnt));

    prim_diff_decode_mc #(.NumChan(NCH), .AsyncOn(1'b0), .MaxSkew(MAXSKEW), .CntW(2)) u_sat (
        .clk_i(clk), .rst_i(rst), .diff_pi(diff_p), .diff_ni(diff_n),
        .level_o(s_level), .rise_o(s_rise), .fall_o(s_fall), .event_o(s_event),
        .sigint_o(s_sig), .sigint_any_o(s_any), .sticky_clr_i(sticky_clr),
        .sigint_sticky_o(s_stk), .cnt_clr_i(cnt_clr), .err_cnt_o(s_cnt));

    prim_diff_decode_mc #(.NumChan(NCH), .AsyncOn(1'b1), .MaxSkew(MAXSKEW), .CntW(8)) u_async (
        .clk_i(clk), .rst_i(rst), .diff_pi(diff_p), .diff_ni(diff_n),
        .level_o(a_level), .rise_o(a_rise), .fall_o(a_fall), .event_o(a_event),
        .sigint_o(a_sig), .sigint_any_o(a_any), .sticky_clr_i(sticky_clr),
        .sigint_sticky_o(a_stk), .cnt_clr_i(cnt_clr), .err_cnt_o(a_cnt));

    int checks = 0;
    int errors = 0;

    // Model: view 0 sees the wires directly, view 1 sees them two cycles late.
    // A channel is "aligned" (lag 0), "lagging" (lag>0) or "faulted".
    bit [NCH-1:0] lvl[2], pq[2], nq[2], stk[2], flt[2], vin_p[2];
    bit [NCH-1:0] e_lvl[2], e_rise[2], e_fall[2], e_sig[2], e_ent[2], n_flt[2];
    int           lag[2][NCH], n_lag[2][NCH];
    bit [NCH-1:0] s1p, s2p, s1n, s2n;
    int           cnt_a, cnt_b, cnt_c;

    logic [NCH-1:0] snap_d_rise, snap_d_sig, snap_d_lvl, snap_d_stk, snap_a_rise, snap_a_lvl;
    logic [7:0]     snap_d_cnt, snap_s_cnt;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int base, input int add, input int mx);
        return (base + add > mx) ? mx : base + add;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            lvl[v] = '0; pq[v] = '0; nq[v] = '1; stk[v] = '0; flt[v] = '0;
            for (int c = 0; c < NCH; c++) lag[v][c] = 0;
        end
        s1p = '0; s2p = '0; s1n = '1; s2n = '1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
    endtask

    // One clock cycle: drive at the falling edge, check 1ns later, advance model at the rising edge.
    task automatic step(input logic [NCH-1:0] p, input logic [NCH-1:0] n,
                        input logic [NCH-1:0] sclr, input logic cclr, input logic r);
        diff_p = p; diff_n = n; sticky_clr = sclr; cnt_clr = cclr; rst = r;
        #1;
        for (int v = 0; v < 2; v++) begin
            e_lvl[v] = lvl[v]; e_rise[v] = '0; e_fall[v] = '0; e_sig[v] = '0; e_ent[v] = '0;
            n_flt[v] = flt[v];
            for (int c = 0; c < NCH; c++) begin
                bit ip, inn, pe, ne, ok;
                ip  = (v == 0) ? p[c] : s2p[c];
                inn = (v == 0) ? n[c] : s2n[c];
                vin_p[v][c] = ip;
                pe = ip ^ pq[v][c];
                ne = inn ^ nq[v][c];
                ok = ip ^ inn;
                n_lag[v][c] = lag[v][c];
                if (flt[v][c]) begin
                    if (ok) n_flt[v][c] = 1'b0;
                    else    e_sig[v][c] = 1'b1;
                end else if (ok) begin
                    if (lag[v][c] > 0 || (pe && ne)) begin
                        e_rise[v][c] = ip;
                        e_fall[v][c] = !ip;
                    end
                    e_lvl[v][c] = ip;
                    n_lag[v][c] = 0;
                end else if (lag[v][c] == 0 && (pe != ne)) begin
                    n_lag[v][c] = 1;
                end else if (lag[v][c] > 0 && lag[v][c] < MAXSKEW) begin
                    n_lag[v][c] = lag[v][c] + 1;
                end else begin
                    n_flt[v][c] = 1'b1; n_lag[v][c] = 0;
                    e_sig[v][c] = 1'b1; e_ent[v][c] = 1'b1;
                end
            end
        end
        if (!r) begin
            chk("d.level", d_level, e_lvl[0]);   chk("d.rise", d_rise, e_rise[0]);
            chk("d.fall", d_fall, e_fall[0]);    chk("d.event", d_event, e_rise[0] | e_fall[0]);
            chk("d.sigint", d_sig, e_sig[0]);    chk("d.any", d_any, |e_sig[0]);
            chk("d.rise_and_fall", d_rise & d_fall, 0);
            chk("s.level", s_level, e_lvl[0]);   chk("s.rise", s_rise, e_rise[0]);
            chk("s.fall", s_fall, e_fall[0]);    chk("s.event", s_event, e_rise[0] | e_fall[0]);
            chk("s.sigint", s_sig, e_sig[0]);    chk("s.any", s_any, |e_sig[0]);
            chk("a.level", a_level, e_lvl[1]);   chk("a.rise", a_rise, e_rise[1]);
            chk("a.fall", a_fall, e_fall[1]);    chk("a.event", a_event, e_rise[1] | e_fall[1]);
            chk("a.sigint", a_sig, e_sig[1]);    chk("a.any", a_any, |e_sig[1]);
        end
        chk("d.sticky", d_stk, stk[0]); chk("s.sticky", s_stk, stk[0]); chk("a.sticky", a_stk, stk[1]);
        chk("d.cnt", d_cnt, cnt_a[7:0]); chk("s.cnt", s_cnt, cnt_b[7:0]); chk("a.cnt", a_cnt, cnt_c[7:0]);
        snap_d_rise = d_rise; snap_d_sig = d_sig; snap_d_lvl = d_level; snap_d_stk = d_stk;
        snap_a_rise = a_rise; snap_a_lvl = a_level; snap_d_cnt = d_cnt; snap_s_cnt = 8'(s_cnt);
        @(posedge clk);
        if (r) model_reset();
        else begin
            for (int v = 0; v < 2; v++) begin
                flt[v] = n_flt[v]; lvl[v] = e_lvl[v];
                stk[v] = e_ent[v] | (stk[v] & ~sclr);
                pq[v]  = vin_p[v];
                nq[v]  = (v == 0) ? n : s2n;
                for (int c = 0; c < NCH; c++) lag[v][c] = n_lag[v][c];
            end
            cnt_a = sat(cclr ? 0 : cnt_a, $countones(e_ent[0]), 255);
            cnt_b = sat(cclr ? 0 : cnt_b, $countones(e_ent[0]), 3);
            cnt_c = sat(cclr ? 0 : cnt_c, $countones(e_ent[1]), 255);
            s2p = s1p; s1p = p; s2n = s1n; s1n = n;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [NCH-1:0] rp, rn, rclr;
        rst = 1'b1; diff_p = '0; diff_n = '1; sticky_clr = '0; cnt_clr = 1'b0;
        model_reset();
        @(negedge clk);
        // Reset state
        repeat (3) step(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("rst.cnt", snap_d_cnt, 8'd0); chk("rst.level", snap_d_lvl, 4'b0000);
        chk("rst.sticky", snap_d_stk, 4'b0000);

        // Clean rise then fall on ch0
        step(4'b0001, 4'b1110, 4'b0000, 1'b0, 1'b0);
        chk("rise.pulse", snap_d_rise, 4'b0001); chk("rise.level", snap_d_lvl, 4'b0001);
        step(4'b0001, 4'b1110, 4'b0000, 1'b0, 1'b0);
        chk("rise.one_cycle", snap_d_rise, 4'b0000);
        step(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("fall.level", snap_d_lvl, 4'b0000);

        // n lags p by two cycles on ch0: tolerated, single rise on correction
        step(4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("skew.norise1", snap_d_rise, 4'b0000);
        step(4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("skew.nosig", snap_d_sig, 4'b0000);
        step(4'b0001, 4'b1110, 4'b0000, 1'b0, 1'b0);
        chk("skew.rise", snap_d_rise, 4'b0001);

        // n lags three cycles on ch1: fault, then silent recovery
        repeat (2) step(4'b0011, 4'b1110, 4'b0000, 1'b0, 1'b0);
        step(4'b0011, 4'b1110, 4'b0000, 1'b0, 1'b0);
        chk("fault.sigint", snap_d_sig, 4'b0010);
        step(4'b0011, 4'b1100, 4'b0000, 1'b0, 1'b0);
        chk("fault.sticky", snap_d_stk, 4'b0010); chk("fault.cnt", snap_d_cnt, 8'd1);
        chk("fault.cleared", snap_d_sig, 4'b0000); chk("fault.nopulse", snap_d_rise, 4'b0000);
        chk("fault.level_held", snap_d_lvl, 4'b0001);

        // ch3 fault brings counts to 2, then three simultaneous entries
        repeat (3) step(4'b1011, 4'b1100, 4'b0000, 1'b0, 1'b0);
        step(4'b0011, 4'b1100, 4'b0000, 1'b0, 1'b0);
        chk("cnt.two", snap_s_cnt, 8'd2);
        repeat (3) step(4'b0111, 4'b1111, 4'b0000, 1'b0, 1'b0);
        step(4'b0011, 4'b1100, 4'b0000, 1'b0, 1'b0);
        chk("cnt.plus3", snap_d_cnt, 8'd5); chk("cnt.saturated", snap_s_cnt, 8'd3);

        // Clear sticky[1], then a fault entry coinciding with sticky and count clears
        step(4'b0011, 4'b1100, 4'b0010, 1'b0, 1'b0);
        repeat (2) step(4'b0011, 4'b1110, 4'b0010, 1'b0, 1'b0);
        step(4'b0011, 4'b1110, 4'b0010, 1'b1, 1'b0);
        chk("clr.sticky_cleared", snap_d_stk, 4'b1101);
        step(4'b0011, 4'b1100, 4'b0000, 1'b0, 1'b0);
        chk("clr.set_wins", snap_d_stk, 4'b1111);
        chk("clr.cnt", snap_d_cnt, 8'd1); chk("clr.sat_cnt", snap_s_cnt, 8'd1);

        // Synchronised instance: reset while skewed, then measure 2-cycle latency
        repeat (3) step(4'b0011, 4'b1100, 4'b0000, 1'b0, 1'b0);
        repeat (3) step(4'b0011, 4'b1101, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("arst.level", snap_a_lvl, 4'b0000); chk("arst.rise", snap_a_rise, 4'b0000);
        step(4'b0001, 4'b1110, 4'b0000, 1'b0, 1'b0);
        chk("alat.c0", snap_a_rise, 4'b0000); chk("alat.direct", snap_d_rise, 4'b0001);
        step(4'b0001, 4'b1110, 4'b0000, 1'b0, 1'b0);
        chk("alat.c1", snap_a_rise, 4'b0000);
        step(4'b0001, 4'b1110, 4'b0000, 1'b0, 1'b0);
        chk("alat.c2", snap_a_rise, 4'b0001); chk("alat.level", snap_a_lvl, 4'b0001);

        // Random traffic: clean toggles, single-wire lags, restores, clears, resets
        rp = 4'b0001; rn = 4'b1110;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++) begin
                case ($urandom_range(0, 9))
                    5, 6:    begin rp[c] = ~rp[c]; rn[c] = ~rp[c]; end
                    7:       rp[c] = ~rp[c];
                    8:       rn[c] = ~rn[c];
                    9:       rn[c] = ~rp[c];
                    default: ;
                endcase
                rclr[c] = ($urandom_range(0, 7) == 0);
            end
            step(rp, rn, rclr, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
